// File: rtl/div_issue_ctrl.sv
// Issue/retire controller around an 8-stage unsigned divider pipeline: sign handling,
// RV32M corner cases, in-order result FIFO and credit-based backpressure.
module div_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [3:0]  in_tag,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_tag
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both high;
  // ready never depends on valid, and valid/payload are held until the transfer.

  localparam int DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic        neg_q;
    logic        neg_r;
    logic        spec;
    logic [31:0] spec_res;
  } meta_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] result;
  } entry_t;

  logic [3:0] credit_q, credit_d;
  meta_t      meta_q [DEPTH];
  meta_t      meta_d [DEPTH];
  entry_t     mem_q  [DEPTH];
  entry_t     mem_d  [DEPTH];
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;

  logic        accept;
  logic        pop;
  logic        push;
  logic        is_signed;
  logic        is_rem;
  logic        div_by_zero;
  logic        overflow;
  meta_t       new_meta;
  meta_t       tail;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] result;

  // Front end: operand conditioning and per-request metadata.
  always_comb begin
    is_signed    = ~in_op[0];
    is_rem       = in_op[1];
    // Gated by rst so nothing is taken in the reset cycle itself.
    in_ready     = ~rst & (credit_q < 4'd8);
    accept       = in_valid & in_ready;
    div_dividend = (is_signed & in_a[31]) ? (~in_a + 32'd1) : in_a;
    div_divisor  = (is_signed & in_b[31]) ? (~in_b + 32'd1) : in_b;
    div_by_zero  = (in_b == 32'd0);
    overflow     = is_signed & (in_a == 32'h8000_0000) & (in_b == 32'hFFFF_FFFF);

    new_meta       = '0;
    new_meta.valid = 1'b1;
    new_meta.op    = in_op;
    new_meta.tag   = in_tag;
    new_meta.neg_q = is_signed & (in_a[31] ^ in_b[31]);
    new_meta.neg_r = is_signed & in_a[31];
    new_meta.spec  = div_by_zero | overflow;
    if (div_by_zero) begin
      new_meta.spec_res = is_rem ? in_a : 32'hFFFF_FFFF;
    end else if (overflow) begin
      new_meta.spec_res = is_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  // Metadata travels alongside the divider; slot DEPTH-1 lines up with its output.
  always_comb begin
    meta_d[0] = accept ? new_meta : '0;
    for (int i = 1; i < DEPTH; i++) begin
      meta_d[i] = meta_q[i-1];
    end
  end

  // Back end: sign fix-up, special override, FIFO and credit bookkeeping.
  always_comb begin
    tail  = meta_q[DEPTH-1];
    q_fix = tail.neg_q ? (~div_quotient + 32'd1) : div_quotient;
    r_fix = tail.neg_r ? (~div_remainder + 32'd1) : div_remainder;
    case (tail.op)
      2'b00, 2'b01: result = q_fix;
      default:      result = r_fix;
    endcase
    if (tail.spec) begin
      result = tail.spec_res;
    end
    push = tail.valid;

    out_valid  = (count_q != 4'd0);
    pop        = out_valid & out_ready;
    out_result = out_valid ? mem_q[rd_ptr_q].result : 32'd0;
    out_tag    = out_valid ? mem_q[rd_ptr_q].tag : 4'd0;

    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = {tail.tag, result};
    end
    wr_ptr_d = wr_ptr_q + {2'b00, push};
    rd_ptr_d = rd_ptr_q + {2'b00, pop};
    count_d  = count_q + {3'b000, push} - {3'b000, pop};
    // Credit covers both in-flight and queued entries, so the FIFO can never overflow.
    credit_d = credit_q + {3'b000, accept} - {3'b000, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= 4'd0;
      count_q  <= 4'd0;
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      credit_q <= credit_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= meta_d[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed + random bench for div_issue_ctrl with a behavioural 8-stage divider and
// an in-order scoreboard of {tag, result}.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [3:0]  in_tag = 4'd0;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_tag;

  div_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_tag       (in_tag),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural 8-stage unsigned divider ----------------
  logic [31:0] pq [8];
  logic [31:0] pr [8];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        pq[i] <= 32'd0;
        pr[i] <= 32'd0;
      end
    end else begin
      pq[0] <= (div_divisor == 32'd0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
      pr[0] <= (div_divisor == 32'd0) ? div_dividend : div_dividend % div_divisor;
      for (int i = 1; i < 8; i++) begin
        pq[i] <= pq[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end
  assign div_quotient  = pq[7];
  assign div_remainder = pr[7];

  // ---------------- checking ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [35:0] exp_q [$];
  int acc_cyc   = 0;
  int outst     = 0;
  int max_outst = 0;
  int pop_cnt   = 0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      2'b01: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b10: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard monitor: pops the expected queue on every output handshake.
  logic [35:0] mon_e;
  always @(negedge clk) begin
    if (rst) begin
      outst = 0;
    end else begin
      if (in_valid && in_ready) outst++;
      if (out_valid && out_ready) begin
        outst--;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_result", 36'(out_valid), 36'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", {out_tag, out_result}, mon_e);
        end
      end
      if (outst > max_outst) max_outst = outst;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Call only just after a rising edge; leaves the bench just after a rising edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    int n = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
        exp_q.push_back({tag, ref_result(op, a, b)});
      end
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 36'(in_ready), 36'd1);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 36'(exp_q.size()), 36'd0);
  endtask

  // ---------------- directed sequence ----------------
  int n_acc;
  int pop_before;
  int vcount;
  int wn;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 36'(in_ready), 36'd0);
    chk("rst_out_valid", 36'(out_valid), 36'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 36'(in_ready), 36'd1);
    chk("post_rst_out_valid", 36'(out_valid), 36'd0);
    chk("post_rst_out_result", 36'(out_result), 36'd0);
    chk("post_rst_out_tag", 36'(out_tag), 36'd0);

    // Basic unsigned op and accept-to-out_valid latency
    out_ready = 1'b1;
    align();
    send(2'b01, 32'd100, 32'd7, 4'd3);
    wn = 0;
    while (!out_valid && wn < 30) begin
      @(negedge clk);
      wn++;
    end
    chk("latency", 36'(cyc - acc_cyc), 36'd9);
    wait_drain(30);

    // Sign handling and special cases, back to back
    align();
    send(2'b11, 32'd100, 32'd7, 4'd4);
    send(2'b00, 32'hFFFF_FFF9, 32'd2, 4'd5);
    send(2'b10, 32'hFFFF_FFF9, 32'd2, 4'd6);
    send(2'b10, 32'd7, 32'hFFFF_FFFE, 4'd7);
    send(2'b00, 32'd5, 32'd0, 4'd8);
    send(2'b11, 32'd5, 32'd0, 4'd9);
    send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10);
    send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11);
    send(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12);
    send(2'b10, 32'h8000_0001, 32'd0, 4'd13);
    wait_drain(60);

    // Random mix including zero and small divisors
    align();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 4) == 0) rb = -rb;
      send(2'($urandom_range(0, 3)), ra, rb, 4'(i));
    end
    wait_drain(80);

    // Backpressure: only 8 credits
    out_ready = 1'b0;
    n_acc = 0;
    align();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_op    = 2'b01;
      in_a     = 32'd1000 + 32'(i);
      in_b     = 32'd3;
      in_tag   = 4'(n_acc);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({4'(n_acc), ref_result(2'b01, 32'd1000 + 32'(i), 32'd3)});
        n_acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 36'(n_acc), 36'd8);
    repeat (12) @(negedge clk);
    chk("bp_in_ready_low", 36'(in_ready), 36'd0);
    chk("bp_out_valid", 36'(out_valid), 36'd1);
    chk("bp_hold_head", {out_tag, out_result}, exp_q[0]);
    @(negedge clk);
    chk("bp_hold_head2", {out_tag, out_result}, exp_q[0]);
    pop_before = pop_cnt;
    align();
    out_ready = 1'b1;
    wait_drain(40);
    chk("bp_pop_count", 36'(pop_cnt - pop_before), 36'd8);
    @(negedge clk);
    chk("bp_in_ready_back", 36'(in_ready), 36'd1);

    // Streaming 16 requests with out_ready high
    max_outst = 0;
    pop_before = pop_cnt;
    align();
    for (int t = 0; t < 16; t++) begin
      send(2'b01, $urandom, 32'($urandom_range(1, 1000)), 4'(t));
    end
    wait_drain(60);
    chk("stream_pop_count", 36'(pop_cnt - pop_before), 36'd16);
    chk("stream_max_outstanding", 36'(max_outst), 36'd8);

    // Reset with requests in flight
    align();
    for (int t = 0; t < 5; t++) begin
      send(2'b00, 32'hFFFF_FF00 + 32'(t), 32'd3, 4'(t));
    end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 36'(in_ready), 36'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    vcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("midrst_no_stale", 36'(vcount), 36'd0);
    align();
    send(2'b00, 32'hFFFF_FF9C, 32'd7, 4'd14);
    wait_drain(30);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
